// File: rtl/tarot_draw.sv
// tarot_draw: draws SPREAD distinct card indices from PRNG words and streams them, then a
// terminator byte (FF normal, FE abort), to a UART transmitter one byte at a time.
module tarot_draw #(
   parameter int NUM_CARDS  = 78,
   parameter int SPREAD     = 3,
   parameter int MAX_REJECT = 255
) (
   input  logic        sysclk,
   input  logic        rst_n,
   input  logic        draw_start,
   input  logic        rand_valid,
   input  logic [31:0] rand_data,
   output logic        rand_ready,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   input  logic        tx_done,
   output logic        busy,
   output logic        err
);
   typedef enum logic [2:0] {IDLE, WAIT_RAND, CHECK, SEND, WAIT_TX, TERM, WAIT_TERM} state_t;
   localparam logic [7:0] NC = 8'(NUM_CARDS);
   localparam logic [7:0] MR = 8'(MAX_REJECT);
   localparam logic [2:0] SP = 3'(SPREAD);
   state_t       state_q, state_d;
   logic [127:0] drawn_q, drawn_d;
   logic [2:0]   cnt_q, cnt_d;
   logic [7:0]   rej_q, rej_d, rej_inc, tx_data_q, tx_data_d;
   logic [6:0]   cand_q, cand_d;
   logic         rev_q, rev_d, err_q, err_d, reject;
   logic         unused_rand;
   assign unused_rand = ^{rand_data[30:23], rand_data[15:0]};
   assign rand_ready  = state_q == WAIT_RAND;
   assign tx_start    = state_q == SEND || state_q == TERM;
   assign busy        = state_q != IDLE;
   assign err         = err_q;
   assign tx_data     = tx_data_q;
   assign reject      = {1'b0, cand_q} >= NC || drawn_q[cand_q];
   assign rej_inc     = rej_q == 8'hFF ? rej_q : rej_q + 8'd1;
   always_comb begin
      state_d   = state_q;
      drawn_d   = drawn_q;
      cnt_d     = cnt_q;
      rej_d     = rej_q;
      cand_d    = cand_q;
      rev_d     = rev_q;
      err_d     = err_q;
      tx_data_d = tx_data_q;
      case (state_q)
         IDLE: if (draw_start) begin
            drawn_d = '0;
            cnt_d   = '0;
            rej_d   = '0;
            err_d   = 1'b0;
            state_d = WAIT_RAND;
         end
         WAIT_RAND: if (rand_valid) begin
            cand_d  = rand_data[22:16];
            rev_d   = rand_data[31];
            state_d = CHECK;
         end
         CHECK: if (reject) begin
            rej_d = rej_inc;
            if (rej_inc >= MR) begin
               err_d     = 1'b1;
               tx_data_d = 8'hFE;
               state_d   = TERM;
            end else state_d = WAIT_RAND;
         end else begin
            drawn_d[cand_q] = 1'b1;
            rej_d           = '0;
            tx_data_d       = {rev_q, cand_q};
            state_d         = SEND;
         end
         SEND: state_d = WAIT_TX;
         WAIT_TX: if (tx_done) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_d == SP) begin
               tx_data_d = 8'hFF;
               state_d   = TERM;
            end else state_d = WAIT_RAND;
         end
         TERM: state_d = WAIT_TERM;
         WAIT_TERM: state_d = tx_done ? IDLE : WAIT_TERM;
         default: state_d = IDLE;
      endcase
   end
   // Reset abandons any byte in flight; the UART is not consulted.
   always_ff @(posedge sysclk or posedge rst_n) begin
      if (rst_n) begin
         state_q   <= IDLE;
         drawn_q   <= '0;
         cnt_q     <= '0;
         rej_q     <= '0;
         cand_q    <= '0;
         rev_q     <= 1'b0;
         err_q     <= 1'b0;
         tx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         drawn_q   <= drawn_d;
         cnt_q     <= cnt_d;
         rej_q     <= rej_d;
         cand_q    <= cand_d;
         rev_q     <= rev_d;
         err_q     <= err_d;
         tx_data_q <= tx_data_d;
      end
   end
endmodule

// File: doc/tarot_draw.md
TAROT_DRAW -- requirements
Module: tarot_draw

Interface
REQ-001 Parameter NUM_CARDS, default 78, number of distinct card indices (0..NUM_CARDS-1, maximum 127).
REQ-002 Parameter SPREAD, default 3, number of cards drawn per request (1..7).
REQ-003 Parameter MAX_REJECT, default 255, consecutive rejected candidates before abort.
REQ-004 sysclk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-high (asserted = 1, despite the name).
REQ-006 draw_start  in  1  one-cycle pulse requesting a new spread.
REQ-007 rand_valid  in  1  one-cycle pulse; rand_data holds a fresh PRNG word.
REQ-008 rand_data  in  32  PRNG word (Henon x output).
REQ-009 rand_ready  out  1  high while the block will accept a rand_valid.
REQ-010 tx_start  out  1  one-cycle pulse to the UART transmitter.
REQ-011 tx_data  out  8  byte to transmit; stable from tx_start until tx_done.
REQ-012 tx_done  in  1  UART byte-complete indication (level or pulse; sampled high = complete).
REQ-013 busy  out  1  high from accepted draw_start until return to IDLE.
REQ-014 err  out  1  sticky abort flag; cleared by the next accepted draw_start.

Function
REQ-015 States: IDLE, WAIT_RAND, CHECK, SEND, WAIT_TX, TERM, WAIT_TERM; no other encodings reachable.
REQ-016 IDLE: draw_start=1 -> clear 128-bit drawn mask, card count, reject count, err; go WAIT_RAND. draw_start in any other state is ignored.
REQ-017 rand_ready = 1 only in WAIT_RAND; rand_valid with rand_ready=0 is discarded.
REQ-018 WAIT_RAND: rand_valid=1 -> register cand = rand_data[22:16] (7 bits), rev = rand_data[31]; go CHECK next cycle.
REQ-019 CHECK: cand >= NUM_CARDS or drawn[cand]=1 -> reject: increment reject count, return WAIT_RAND; else accept: set drawn[cand], reset reject count, load tx_data = {rev, cand}, go SEND.
REQ-020 CHECK rejection bringing reject count to MAX_REJECT -> set err, load tx_data = 8'hFE, go TERM instead of WAIT_RAND.
REQ-021 SEND: tx_start=1 for exactly one cycle, go WAIT_TX; latency rand_valid accepted (cycle N) -> tx_start high at cycle N+2.
REQ-022 WAIT_TX: tx_start=0; hold until tx_done=1 sampled; tx_done is ignored during the tx_start cycle itself.
REQ-023 On tx_done in WAIT_TX: card count+1; count = SPREAD -> load tx_data = 8'hFF, go TERM; else go WAIT_RAND.
REQ-024 TERM: pulse tx_start one cycle, go WAIT_TERM; tx_done there -> IDLE, busy=0.
REQ-025 Exactly SPREAD card bytes then 8'hFF per normal request; abort emits accepted cards so far then 8'hFE only.
REQ-026 No card index repeats within one spread; indices >= NUM_CARDS never emitted.
REQ-027 Reject counter saturating 8-bit; card counter 3-bit; no wrap-around reachable.

Reset
REQ-028 rst_n=1 at any time, including mid-transmission -> immediately IDLE; tx_start=0, tx_data=8'h00, rand_ready=0, busy=0, err=0, drawn mask=0, all counters 0.
REQ-029 After rst_n deasserts, first draw_start accepted on the first rising edge it is sampled.
REQ-030 Reset does not wait for tx_done; a byte in flight at the UART is abandoned.

Verification
REQ-031 SPREAD=3, words with [22:16]=5,17,40, [31]=0,1,0, tx_done 10 cycles after each tx_start -> bytes 0x05,0x91,0x28,0xFF; busy falls after final tx_done.
REQ-032 Words with [22:16]=100, 78, then 12 -> two rejects, single byte 0x0C; tx_start exactly 2 cycles after the accepted rand_valid.
REQ-033 Word [22:16]=12 accepted, then repeated 12, then 13 -> second 12 rejected; bytes 0x0C,0x0D.
REQ-034 MAX_REJECT=4, four words with [22:16]=127 -> err=1, single byte 0xFE, return IDLE; next draw_start clears err.
REQ-035 rst_n pulsed during WAIT_TX of second card -> all outputs at reset values that edge; new draw_start yields a full fresh spread, previously drawn indices allowed again.
REQ-036 rand_valid pulses in IDLE/WAIT_TX and draw_start while busy -> no state change, no extra bytes.
